// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: synchronize, debounce and edge-detect raw GPIO pins with sticky events and irq
module gpio_in_debounce #(
   parameter int WIDTH = 12,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic [WIDTH-1:0] evt_o,
   input  logic [WIDTH-1:0] evt_clr_i,
   output logic             irq_o
);
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   logic [WIDTH-1:0] s1, s2, flip, evt_n;
   logic [CNT_WIDTH-1:0] cnt [WIDTH];
   // a bit flips when its synchronized level has disagreed for the full count
   always_comb begin
      flip = '0;
      for (int i = 0; i < WIDTH; i++) flip[i] = (s2[i] != stable_o[i]) && (cnt[i] == LAST);
      evt_n = (evt_o & ~evt_clr_i) | flip;
   end
   // synchronizer, stability counters, level/pulse/event registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1 <= '0;
         s2 <= '0;
         stable_o <= '0;
         rise_o <= '0;
         fall_o <= '0;
         evt_o <= '0;
         irq_o <= 1'b0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         s1 <= raw_i;
         s2 <= s1;
         stable_o <= stable_o ^ flip;
         rise_o <= flip & s2;
         fall_o <= flip & ~s2;
         evt_o <= evt_n;
         irq_o <= |evt_n;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= (s2[i] == stable_o[i] || flip[i]) ? '0 : cnt[i] + CNT_WIDTH'(1);
      end
   end
endmodule
